// File: rtl/toggle_decoder_if.sv
// rtl/toggle_decoder_if.sv - decoded-event valid/ready channel of the toggle-line receiver
interface toggle_decoder_if;
    logic ev_valid;
    logic ev_ready;
    logic ev_phase;

    modport master (
        output ev_valid,
        output ev_phase,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_phase,
        output ev_ready
    );
endinterface

// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - toggle-line receiver: synchroniser, glitch filter, pending-event counter
module toggle_decoder #(
    parameter int FILT_CYCLES = 4,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                line_in,
    toggle_decoder_if.master    ev_if,
    output logic [CNT_W-1:0]    ev_count,
    output logic                overflow,
    input  logic                clr
);

    // qcnt only ever counts up to FILT_CYCLES-1; keep it at least one bit wide
    localparam int QW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [QW-1:0]     QLAST    = QW'(FILT_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_QUALIFY = 1'b1
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_lvl;
    state_t            r_state;
    logic [QW-1:0]     r_qcnt;
    logic [PEND_W-1:0] r_pend;
    logic [CNT_W-1:0]  r_ev_count;
    logic              r_overflow;

    state_t            w_state_nxt;
    logic [QW-1:0]     w_qcnt_nxt;
    logic              w_lvl_nxt;
    logic              w_ev_acc;
    logic              w_valid;
    logic              w_handshake;
    logic              w_full;
    logic              w_drop;

    // two-flop synchroniser for the asynchronous line
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= line_in;
            r_sync2 <= r_sync1;
        end
    end

    // filter state, qualify counter and accepted level
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_STABLE;
            r_qcnt  <= '0;
            r_lvl   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_lvl   <= w_lvl_nxt;
        end
    end

    // a new level must persist FILT_CYCLES synced cycles before it is accepted
    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_lvl_nxt   = r_lvl;
        w_ev_acc    = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (r_sync2 != r_lvl) begin
                    if (FILT_CYCLES == 1) begin
                        w_lvl_nxt   = r_sync2;
                        w_qcnt_nxt  = '0;
                        w_ev_acc    = 1'b1;
                    end else begin
                        w_state_nxt = ST_QUALIFY;
                        w_qcnt_nxt  = QW'(1);
                    end
                end
            end
            ST_QUALIFY: begin
                if (r_sync2 == r_lvl) begin
                    // line fell back before qualifying: treat as a glitch
                    w_state_nxt = ST_STABLE;
                    w_qcnt_nxt  = '0;
                end else if (r_qcnt == QLAST) begin
                    w_state_nxt = ST_STABLE;
                    w_qcnt_nxt  = '0;
                    w_lvl_nxt   = r_sync2;
                    w_ev_acc    = 1'b1;
                end else begin
                    w_qcnt_nxt  = r_qcnt + QW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_qcnt_nxt  = '0;
            end
        endcase
    end

    assign w_valid     = (r_pend != '0);
    assign w_handshake = w_valid && ev_if.ev_ready;
    assign w_full      = (r_pend == PEND_MAX);
    assign w_drop      = w_ev_acc && !w_handshake && w_full;

    // pending-event counter: accept and handshake in one cycle cancel out
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend <= '0;
        end else if (w_ev_acc && !w_handshake && !w_full) begin
            r_pend <= r_pend + PEND_W'(1);
        end else if (w_handshake && !w_ev_acc) begin
            r_pend <= r_pend - PEND_W'(1);
        end
    end

    // saturating count of accepted changes, dropped ones included
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ev_count <= '0;
        end else if (clr) begin
            r_ev_count <= w_ev_acc ? CNT_W'(1) : '0;
        end else if (w_ev_acc && (r_ev_count != CNT_MAX)) begin
            r_ev_count <= r_ev_count + CNT_W'(1);
        end
    end

    // sticky drop flag; a drop in the same cycle as clr keeps it set
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign ev_if.ev_valid = w_valid;
    assign ev_if.ev_phase = r_lvl;
    assign ev_count       = r_ev_count;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - self-checking bench for toggle_decoder
module tb_toggle_decoder;

    logic        clk;
    logic        rst;
    logic        line_in;
    logic        clr;
    logic [15:0] ev_count;
    logic        overflow;

    toggle_decoder_if ev_if ();

    toggle_decoder #(
        .FILT_CYCLES (4),
        .PEND_W      (4),
        .CNT_W       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .line_in  (line_in),
        .ev_if    (ev_if),
        .ev_count (ev_count),
        .overflow (overflow),
        .clr      (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic phase;
        logic chk_phase;
    } sb_t;

    typedef struct {
        int width;
        int exp_events;
    } vec_t;

    sb_t sb_q[$];
    int  n_checks;
    int  n_errors;
    int  n_hs;
    int  exp_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic phase, input logic chk_phase);
        sb_t e;
        e.phase     = phase;
        e.chk_phase = chk_phase;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every handshake must match an event the bench expected
    always @(negedge clk) begin
        if (rst && ev_if.ev_valid && ev_if.ev_ready) begin
            sb_t e;
            n_hs++;
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_event", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (e.chk_phase) chk("sb_phase", 32'(ev_if.ev_phase), 32'(e.phase));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        int   hs0;
        int   k;

        vecs[0] = '{1, 0};
        vecs[1] = '{2, 0};
        vecs[2] = '{3, 0};
        vecs[3] = '{4, 2};
        vecs[4] = '{6, 2};
        vecs[5] = '{10, 2};

        n_checks  = 0;
        n_errors  = 0;
        n_hs      = 0;
        exp_count = 0;

        rst            = 1'b0;
        line_in        = 1'b0;
        clr            = 1'b0;
        ev_if.ev_ready = 1'b0;

        // 1. reset and quiet line
        cyc(3);
        rst = 1'b1;
        cyc(10);
        chk("t1_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("t1_count", 32'(ev_count), 32'd0);
        chk("t1_phase", 32'(ev_if.ev_phase), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // 2. single rising edge, valid exactly 6 cycles later for one cycle
        ev_if.ev_ready = 1'b1;
        @(posedge clk); #1;
        line_in = 1'b1;
        sb_push(1'b1, 1'b1);
        exp_count++;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            chk($sformatf("t2_valid_c%0d", i), 32'(ev_if.ev_valid), 32'(i == 6));
        end
        chk("t2_phase", 32'(ev_if.ev_phase), 32'd1);
        chk("t2_count", 32'(ev_count), 32'(exp_count));
        line_in = 1'b0;
        sb_push(1'b0, 1'b1);
        exp_count++;
        cyc(12);
        chk("t2_count_back", 32'(ev_count), 32'(exp_count));

        // 3. pulse-width table: short pulses are glitches, long ones give two events
        for (int v = 0; v < 6; v++) begin
            @(posedge clk); #1;
            line_in = 1'b1;
            if (vecs[v].exp_events == 2) begin
                sb_push(1'b1, 1'b1);
                sb_push(1'b0, 1'b1);
            end
            exp_count += vecs[v].exp_events;
            cyc(vecs[v].width);
            line_in = 1'b0;
            cyc(14);
            chk($sformatf("t3_count_w%0d", vecs[v].width), 32'(ev_count), 32'(exp_count));
            chk($sformatf("t3_phase_w%0d", vecs[v].width), 32'(ev_if.ev_phase), 32'd0);
            chk($sformatf("t3_valid_w%0d", vecs[v].width), 32'(ev_if.ev_valid), 32'd0);
        end

        // 4. fill the queue with ready low, overflow on the 16th, then drain 15
        ev_if.ev_ready = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_count = 0;
        chk("t4_clr_count", 32'(ev_count), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            line_in = ~line_in;
            if (i <= 15) sb_push(line_in, 1'b0);
            exp_count++;
            cyc(9);
            if (i == 15) begin
                chk("t4_no_overflow_15", 32'(overflow), 32'd0);
                chk("t4_valid_15", 32'(ev_if.ev_valid), 32'd1);
            end
        end
        chk("t4_overflow", 32'(overflow), 32'd1);
        chk("t4_count", 32'(ev_count), 32'd16);
        chk("t4_phase", 32'(ev_if.ev_phase), 32'd0);
        hs0 = n_hs;
        ev_if.ev_ready = 1'b1;
        k = 0;
        while (ev_if.ev_valid && k < 40) begin
            cyc(1);
            k++;
        end
        chk("t4_drained", 32'(ev_if.ev_valid), 32'd0);
        chk("t4_hs_count", 32'(n_hs - hs0), 32'd15);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_count = 0;
        chk("t4_clr_overflow", 32'(overflow), 32'd0);
        chk("t4_clr_count2", 32'(ev_count), 32'd0);

        // 5a. handshake coinciding with an accept while pend=1 keeps pend at 1
        ev_if.ev_ready = 1'b0;
        @(posedge clk); #1;
        line_in = 1'b1;
        sb_push(1'b1, 1'b1);
        exp_count++;
        cyc(9);
        chk("t5_pend1_valid", 32'(ev_if.ev_valid), 32'd1);
        @(posedge clk); #1;
        line_in = 1'b0;
        sb_push(1'b0, 1'b1);
        exp_count++;
        cyc(5);
        ev_if.ev_ready = 1'b1;
        cyc(1);
        ev_if.ev_ready = 1'b0;
        chk("t5_valid_after", 32'(ev_if.ev_valid), 32'd1);
        chk("t5_phase_after", 32'(ev_if.ev_phase), 32'd0);
        cyc(1);
        chk("t5_valid_hold", 32'(ev_if.ev_valid), 32'd1);
        hs0 = n_hs;
        ev_if.ev_ready = 1'b1;
        cyc(3);
        chk("t5_one_left", 32'(n_hs - hs0), 32'd1);
        chk("t5_valid_empty", 32'(ev_if.ev_valid), 32'd0);

        // 5b. clr in the accept cycle leaves ev_count at 1
        @(posedge clk); #1;
        line_in = 1'b1;
        sb_push(1'b1, 1'b1);
        cyc(5);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        exp_count = 1;
        chk("t5_clr_acc_count", 32'(ev_count), 32'd1);
        cyc(4);

        // 6. reset during qualify with three events pending
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            line_in = ~line_in;
            cyc(9);
        end
        chk("t6_pend3_valid", 32'(ev_if.ev_valid), 32'd1);
        @(posedge clk); #1;
        line_in = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("t6_rst_valid", 32'(ev_if.ev_valid), 32'd0);
        chk("t6_rst_count", 32'(ev_count), 32'd0);
        chk("t6_rst_phase", 32'(ev_if.ev_phase), 32'd0);
        chk("t6_rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        ev_if.ev_ready = 1'b1;
        sb_push(1'b1, 1'b1);
        exp_count = 1;
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            chk($sformatf("t6_valid_c%0d", i), 32'(ev_if.ev_valid), 32'(i == 6));
        end
        chk("t6_count", 32'(ev_count), 32'(exp_count));
        chk("t6_phase", 32'(ev_if.ev_phase), 32'd1);

        cyc(4);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
